pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. Decides each cycle which pipeline

---
 rtl/pipeline_hazard_ctrl_if.sv | 42 ++++
 rtl/pipeline_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller port bundle: pipeline status inputs and latch control outputs.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             ihit;
  logic             dhit;
  logic             exmem_dREN;
  logic             exmem_dWEN;
  logic             exmem_redirect;
  logic             idex_dREN;
  logic [4:0]       idex_wsel;
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             ifid_uses_rt;
  logic             halt_wb;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             exmem_flush;
  logic             memwb_en;
  logic             halted;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ihit, dhit, exmem_dREN, exmem_dWEN, exmem_redirect, idex_dREN,
           idex_wsel, ifid_rs, ifid_rt, ifid_uses_rt, halt_wb,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           exmem_flush, memwb_en, halted, mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  ihit, dhit, exmem_dREN, exmem_dWEN, exmem_redirect, idex_dREN,
           idex_wsel, ifid_rs, ifid_rt, ifid_uses_rt, halt_wb,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           exmem_flush, memwb_en, halted, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: dcache wait freeze, redirect
// flush, load-use bubble, icache miss stall and permanent halt, with saturating
// performance counters and a dcache-wait watchdog.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 32,
  parameter int WDOG  = 255
) (
  input logic                   CLK,
  input logic                   RST,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;

  localparam logic [16:0] WDOG_L = 17'(WDOG);

  state_t           state, state_nxt;
  logic             dpend, luse;
  logic             stall_inc, flush_inc;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic             exmem_en, exmem_flush, memwb_en;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [15:0]      wd;
  logic [16:0]      wd_inc;
  logic             timeout;

  assign dpend  = hz.exmem_dREN | hz.exmem_dWEN;
  assign luse   = hz.idex_dREN & (hz.idex_wsel != 5'd0) &
                  ((hz.idex_wsel == hz.ifid_rs) |
                   (hz.ifid_uses_rt & (hz.idex_wsel == hz.ifid_rt)));
  assign wd_inc = {1'b0, wd} + 17'd1;

  // Priority decode of latch enables/flushes and next state; reset and HALT force everything off.
  always_comb begin
    state_nxt   = state;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    memwb_en    = 1'b0;
    if (!RST && state != HALT) begin
      if (hz.halt_wb) begin
        state_nxt = HALT;
      end else if (dpend && !hz.dhit) begin
        // Whole pipe frozen; a pending redirect survives in the frozen EX/MEM latch.
        state_nxt = DWAIT;
        stall_inc = 1'b1;
      end else begin
        state_nxt = RUN;
        if (hz.exmem_redirect) begin
          pc_en       = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          memwb_en    = 1'b1;
          flush_inc   = 1'b1;
        end else if (luse) begin
          idex_flush = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
          stall_inc  = 1'b1;
        end else if (!hz.ihit) begin
          ifid_flush = 1'b1;
          idex_en    = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
          stall_inc  = 1'b1;
        end else begin
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
        end
      end
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= RUN;
    else     state <= state_nxt;
  end

  // Saturating stall and flush counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  // Watchdog: counts cycles spent in DWAIT, sets a sticky timeout flag at WDOG.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wd      <= '0;
      timeout <= 1'b0;
    end else if (state == DWAIT) begin
      if (wd != 16'hFFFF) wd <= wd_inc[15:0];
      if (wd_inc >= WDOG_L) timeout <= 1'b1;
    end else begin
      wd <= '0;
    end
  end

  assign hz.pc_en       = pc_en;
  assign hz.ifid_en     = ifid_en;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_en     = idex_en;
  assign hz.idex_flush  = idex_flush;
  assign hz.exmem_en    = exmem_en;
  assign hz.exmem_flush = exmem_flush;
  assign hz.memwb_en    = memwb_en;
  assign hz.halted      = (state == HALT) & ~RST;
  assign hz.mem_timeout = timeout;
  assign hz.stall_cnt   = stall_cnt;
  assign hz.flush_cnt   = flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a queue scoreboard of expected latch controls.
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam int WDOG  = 4;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en}
  localparam logic [7:0] E_NONE  = 8'b0000_0000;
  localparam logic [7:0] E_ALL   = 8'b1101_0101;
  localparam logic [7:0] E_REDIR = 8'b1010_1011;
  localparam logic [7:0] E_LUSE  = 8'b0000_1101;
  localparam logic [7:0] E_MISS  = 8'b0011_0101;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;
  logic [7:0] exp_q[$];
  string      tag_q[$];

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .WDOG(WDOG)) dut (
    .CLK (clk),
    .RST (rst),
    .hz  (hz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Push expected controls, sample them mid-cycle, then advance past the next rising edge.
  task automatic cyc(input string tag, input logic [7:0] expv);
    logic [7:0] e;
    string      t;
    exp_q.push_back(expv);
    tag_q.push_back(tag);
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, {24'd0, hz.pc_en, hz.ifid_en, hz.ifid_flush, hz.idex_en, hz.idex_flush,
                   hz.exmem_en, hz.exmem_flush, hz.memwb_en}, {24'd0, e});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.ihit = 1'b1; hz.dhit = 1'b0; hz.exmem_dREN = 1'b0; hz.exmem_dWEN = 1'b0;
    hz.exmem_redirect = 1'b0; hz.idex_dREN = 1'b0; hz.idex_wsel = 5'd0;
    hz.ifid_rs = 5'd1; hz.ifid_rt = 5'd2; hz.ifid_uses_rt = 1'b0; hz.halt_wb = 1'b0;
  endtask

  task automatic add_stall();
    if (exp_stall < (1 << CNT_W) - 1) exp_stall++;
  endtask

  task automatic chk_regs(input string tag, input logic halted, input logic tmo);
    chk({tag, "_stall_cnt"}, 32'(hz.stall_cnt), 32'(exp_stall));
    chk({tag, "_flush_cnt"}, 32'(hz.flush_cnt), 32'(exp_flush));
    chk({tag, "_halted"}, {31'd0, hz.halted}, {31'd0, halted});
    chk({tag, "_mem_timeout"}, {31'd0, hz.mem_timeout}, {31'd0, tmo});
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    cyc({tag, "_r0"}, E_NONE);
    cyc({tag, "_r1"}, E_NONE);
    exp_stall = 0;
    exp_flush = 0;
    chk_regs(tag, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    // T1: reset with every input high.
    rst = 1'b1;
    hz.ihit = 1'b1; hz.dhit = 1'b1; hz.exmem_dREN = 1'b1; hz.exmem_dWEN = 1'b1;
    hz.exmem_redirect = 1'b1; hz.idex_dREN = 1'b1; hz.idex_wsel = 5'h1F;
    hz.ifid_rs = 5'h1F; hz.ifid_rt = 5'h1F; hz.ifid_uses_rt = 1'b1; hz.halt_wb = 1'b1;
    do_reset("t1");
    idle();
    cyc("t1_run", E_ALL);

    // T2: load-use on rs, on r0, on rt.
    hz.idex_dREN = 1'b1; hz.idex_wsel = 5'd8; hz.ifid_rs = 5'd8;
    cyc("t2_luse_rs", E_LUSE); add_stall();
    hz.idex_dREN = 1'b0;
    cyc("t2_after", E_ALL);
    hz.idex_dREN = 1'b1; hz.idex_wsel = 5'd0; hz.ifid_rs = 5'd0;
    cyc("t2_r0", E_ALL);
    hz.idex_wsel = 5'd9; hz.ifid_rs = 5'd3; hz.ifid_rt = 5'd9; hz.ifid_uses_rt = 1'b1;
    cyc("t2_luse_rt", E_LUSE); add_stall();
    hz.ifid_uses_rt = 1'b0;
    cyc("t2_rt_unused", E_ALL);
    chk_regs("t2", 1'b0, 1'b0);

    // Icache miss, luse over miss, redirect over luse.
    idle(); hz.ihit = 1'b0;
    cyc("miss", E_MISS); add_stall();
    hz.idex_dREN = 1'b1; hz.idex_wsel = 5'd4; hz.ifid_rs = 5'd4;
    cyc("luse_over_miss", E_LUSE); add_stall();
    hz.exmem_redirect = 1'b1;
    cyc("redir_over_luse", E_REDIR); exp_flush++;
    chk_regs("prio", 1'b0, 1'b0);

    // T3: dcache wait for 3 cycles, advance on dhit.
    idle(); hz.exmem_dREN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc("t3_wait", E_NONE); add_stall();
    end
    hz.dhit = 1'b1;
    cyc("t3_dhit", E_ALL);
    idle();
    cyc("t3_run", E_ALL);
    chk_regs("t3", 1'b0, 1'b0);

    // T4: redirect held behind a store miss.
    idle(); hz.exmem_dWEN = 1'b1; hz.exmem_redirect = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc("t4_wait", E_NONE); add_stall();
    end
    hz.dhit = 1'b1;
    cyc("t4_redir", E_REDIR); exp_flush++;
    idle();
    cyc("t4_run", E_ALL);
    chk_regs("t4", 1'b0, 1'b0);

    // T5: watchdog; stall counter also saturates here.
    idle(); hz.exmem_dREN = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cyc("t5_wait", E_NONE); add_stall();
      chk("t5_timeout", {31'd0, hz.mem_timeout}, {31'd0, (i >= 5)});
    end
    chk("t5_sat", 32'(hz.stall_cnt), 32'((1 << CNT_W) - 1));
    hz.dhit = 1'b1;
    cyc("t5_dhit", E_ALL);
    idle();
    cyc("t5_run", E_ALL);
    chk_regs("t5", 1'b0, 1'b1);
    do_reset("t5rst");

    // Reset in the middle of a dcache wait returns to RUN.
    idle(); hz.exmem_dREN = 1'b1;
    cyc("mid_wait0", E_NONE); add_stall();
    cyc("mid_wait1", E_NONE); add_stall();
    do_reset("midrst");
    idle();
    cyc("mid_run", E_ALL);

    // T6: halt is absorbing until reset.
    hz.halt_wb = 1'b1;
    cyc("t6_halt", E_NONE);
    hz.halt_wb = 1'b0;
    chk_regs("t6a", 1'b1, 1'b0);
    cyc("t6_idle", E_NONE);
    hz.idex_dREN = 1'b1; hz.idex_wsel = 5'd5; hz.ifid_rs = 5'd5;
    cyc("t6_luse", E_NONE);
    hz.exmem_redirect = 1'b1;
    cyc("t6_redir", E_NONE);
    idle(); hz.ihit = 1'b0; hz.exmem_dREN = 1'b1;
    cyc("t6_miss", E_NONE);
    chk_regs("t6b", 1'b1, 1'b0);
    do_reset("t6rst");
    idle();
    cyc("t6_resume", E_ALL);
    hz.ihit = 1'b0;
    cyc("t6_resume_miss", E_MISS); add_stall();
    chk_regs("t6c", 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
